dct_seq_ctrl: RTL and testbench

Parametrised control sequencer for the DCT datapath. It steps one or more DCT_POINT-sample blocks through five phases: load first half, load second half with MSPS, MSPS drain, CORDIC, output. It owns its own sample counter, accepts multi-block and continuous runs, and supports abort. An optional watchdog traps stalled phases. It sits between the top-level start logic and the memory, MSPS, CORDIC and output stages.

---
 rtl/dct_pkg.sv | 42 ++++
 rtl/dct_seq_wdog.sv | 27 ++
 rtl/dct_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dct_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types for the DCT control sequencer: state encoding, stage-control
// bundle and the per-state Moore decode used by the sequencer and its monitor.
package dct_pkg;

    localparam int DCT_POINT_DEF = 16;
    localparam int TALLY_W_DEF   = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_LO = 3'd1,
        LOAD_HI = 3'd2,
        MSPS    = 3'd3,
        CORD    = 3'd4,
        OUT     = 3'd5,
        ERR     = 3'd6
    } state_t;

    typedef struct packed {
        logic clr;
        logic start_mem;
        logic count_en;
        logic msps_en;
        logic cord_en;
        logic out_en;
    } ctrl_t;

    function automatic ctrl_t stage_decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            IDLE:    c.clr = 1'b1;
            LOAD_LO: begin c.start_mem = 1'b1; c.count_en = 1'b1; end
            LOAD_HI: begin c.start_mem = 1'b1; c.count_en = 1'b1; c.msps_en = 1'b1; end
            MSPS:    begin c.count_en = 1'b1; c.msps_en = 1'b1; end
            CORD:    begin c.count_en = 1'b1; c.cord_en = 1'b1; end
            OUT:     begin c.count_en = 1'b1; c.out_en = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dct_seq_wdog.sv
// Wait-phase watchdog for dct_seq_ctrl: counts cycles spent in a wait phase
// and flags expiry in the TIMEOUT-th cycle of that phase.
module dct_seq_wdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic cnt_en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    // Expiry is combinational so an exit flag in the same cycle can still win.
    assign expired = cnt_en && (cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt_en && !expired) begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/dct_seq_ctrl.sv
// Control sequencer for the DCT datapath: load lo/hi, MSPS, CORDIC, output.
// Optional wait-phase watchdog enabled by defining DCT_SEQ_TIMEOUT_EN.
module dct_seq_ctrl
    import dct_pkg::*;
#(
    parameter int DCT_POINT = DCT_POINT_DEF,
    parameter int TALLY_W   = TALLY_W_DEF,
    parameter int BLK_W     = 8,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [BLK_W-1:0]   blocks,
    input  logic               abort,
    input  logic               msps_f,
    input  logic               cord_f,
    input  logic               out_f,
    output logic               clr,
    output logic               start_mem,
    output logic               count_en,
    output logic               msps_en,
    output logic               cord_en,
    output logic               out_en,
    output logic [TALLY_W-1:0] tally,
    output logic [BLK_W-1:0]   blk_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    if ((2 ** TALLY_W) <= DCT_POINT || (2 ** TO_W) <= TIMEOUT || DCT_POINT < 4) begin : g_cfg_check
        $error("dct_seq_ctrl: invalid parameter set");
    end

    localparam logic [TALLY_W-1:0] HALF_LAST = TALLY_W'(DCT_POINT / 2 - 1);
    localparam logic [TALLY_W-1:0] FULL_LAST = TALLY_W'(DCT_POINT - 1);

    state_t             state, nxt;
    logic [TALLY_W-1:0] tally_nxt;
    logic [BLK_W-1:0]   blk_nxt;
    logic [BLK_W-1:0]   blocks_q, blocks_nxt;
    logic               done_nxt, err_q, err_nxt;
    logic               more_blocks;
    logic               wd_expired;
    ctrl_t              ctl;

`ifdef DCT_SEQ_TIMEOUT_EN
    logic wd_count;
    assign wd_count = (state == MSPS) || (state == CORD) || (state == OUT);

    dct_seq_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .restart (nxt != state),
        .cnt_en  (wd_count),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    assign more_blocks = (blocks_q != '0) ? (blk_idx < (blocks_q - BLK_W'(1))) : enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tally    <= '0;
            blk_idx  <= '0;
            blocks_q <= '0;
            done     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= nxt;
            tally    <= tally_nxt;
            blk_idx  <= blk_nxt;
            blocks_q <= blocks_nxt;
            done     <= done_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        nxt        = state;
        tally_nxt  = tally;
        blk_nxt    = blk_idx;
        blocks_nxt = blocks_q;
        done_nxt   = 1'b0;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (enable) begin
                    nxt        = LOAD_LO;
                    blocks_nxt = blocks;
                    tally_nxt  = '0;
                    blk_nxt    = '0;
                end
            end
            LOAD_LO: begin
                tally_nxt = tally + TALLY_W'(1);
                if (tally == HALF_LAST) nxt = LOAD_HI;
            end
            LOAD_HI: begin
                if (tally == FULL_LAST) nxt = MSPS;
                else tally_nxt = tally + TALLY_W'(1);
            end
            MSPS: begin
                if (msps_f) nxt = CORD;
                else if (wd_expired) begin nxt = ERR; err_nxt = 1'b1; end
            end
            CORD: begin
                if (cord_f) nxt = OUT;
                else if (wd_expired) begin nxt = ERR; err_nxt = 1'b1; end
            end
            OUT: begin
                if (out_f) begin
                    if (more_blocks) begin
                        nxt       = LOAD_LO;
                        tally_nxt = '0;
                        blk_nxt   = blk_idx + BLK_W'(1);
                    end else begin
                        nxt      = IDLE;
                        done_nxt = 1'b1;
                    end
                end else if (wd_expired) begin
                    nxt     = ERR;
                    err_nxt = 1'b1;
                end
            end
            ERR:     nxt = ERR;
            default: nxt = IDLE;
        endcase
        // Counters read zero whenever the sequencer sits in IDLE.
        if (nxt == IDLE) begin
            tally_nxt = '0;
            blk_nxt   = '0;
        end
        if (abort && state != IDLE) begin
            nxt       = IDLE;
            tally_nxt = '0;
            blk_nxt   = '0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
        end
    end

    assign ctl       = stage_decode(state);
    assign clr       = ctl.clr;
    assign start_mem = ctl.start_mem;
    assign count_en  = ctl.count_en;
    assign msps_en   = ctl.msps_en;
    assign cord_en   = ctl.cord_en;
    assign out_en    = ctl.out_en;
    assign busy      = (state != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Directed self-checking bench for dct_seq_ctrl (DCT_POINT=16, TIMEOUT=10);
// the watchdog scenario runs when DCT_SEQ_TIMEOUT_EN is defined.
module tb_dct_seq_ctrl;

    localparam logic [5:0] C_IDLE = 6'b100000;
    localparam logic [5:0] C_LO   = 6'b011000;
    localparam logic [5:0] C_HI   = 6'b011100;
    localparam logic [5:0] C_MSPS = 6'b001100;
    localparam logic [5:0] C_CORD = 6'b001010;
    localparam logic [5:0] C_OUT  = 6'b001001;
    localparam logic [5:0] C_ERR  = 6'b000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] blocks = 8'd0;
    logic       abort = 1'b0;
    logic       msps_f = 1'b0;
    logic       cord_f = 1'b0;
    logic       out_f = 1'b0;
    logic       clr, start_mem, count_en, msps_en, cord_en, out_en;
    logic [5:0] tally;
    logic [7:0] blk_idx;
    logic       busy, done, err;
    logic [5:0] ctl;

    int n_chk = 0;
    int n_pass = 0;

    assign ctl = {clr, start_mem, count_en, msps_en, cord_en, out_en};

    always #5 clk = ~clk;

    dct_seq_ctrl #(
        .DCT_POINT (16),
        .TALLY_W   (6),
        .BLK_W     (8),
        .TIMEOUT   (10),
        .TO_W      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .blocks    (blocks),
        .abort     (abort),
        .msps_f    (msps_f),
        .cord_f    (cord_f),
        .out_f     (out_f),
        .clr       (clr),
        .start_mem (start_mem),
        .count_en  (count_en),
        .msps_en   (msps_en),
        .cord_en   (cord_en),
        .out_en    (out_en),
        .tally     (tally),
        .blk_idx   (blk_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_chk++;
        if ({ctl, busy, done, err, tally, blk_idx} !== {C_IDLE, 3'b000, 6'd0, 8'd0})
            $display("FAIL reset_state: ctl=%b busy=%b done=%b err=%b tally=%0d blk=%0d, required ctl=%b others 0",
                     ctl, busy, done, err, tally, blk_idx, C_IDLE);
        else n_pass++;
    endtask

    // One block starting in its first LOAD_LO cycle; each wait phase lasts 3 cycles.
    task automatic run_block(input int blk, input bit last, input bit hold_en);
        logic [5:0] phase_ctl [3];
        int sm;
        phase_ctl[0] = C_MSPS;
        phase_ctl[1] = C_CORD;
        phase_ctl[2] = C_OUT;
        sm = 0;
        enable = hold_en;
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if ({ctl, busy, done, err, tally, blk_idx} !== {(i < 8) ? C_LO : C_HI, 3'b100, 6'(i), 8'(blk)})
                $display("FAIL load_b%0d_c%0d: ctl=%b busy=%b done=%b err=%b tally=%0d blk=%0d, required ctl=%b tally=%0d blk=%0d",
                         blk, i, ctl, busy, done, err, tally, blk_idx, (i < 8) ? C_LO : C_HI, i, blk);
            else n_pass++;
            if (start_mem) sm++;
            if (i == 3) begin msps_f = 1'b1; cord_f = 1'b1; out_f = 1'b1; end
            tick();
            msps_f = 1'b0; cord_f = 1'b0; out_f = 1'b0;
        end
        n_chk++;
        if (sm !== 16) $display("FAIL start_mem_len_b%0d: got %0d cycles, required 16", blk, sm);
        else n_pass++;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3; j++) begin
                n_chk++;
                if ({ctl, busy, done, tally, blk_idx} !== {phase_ctl[p], 2'b10, 6'd15, 8'(blk)})
                    $display("FAIL phase%0d_b%0d_c%0d: ctl=%b busy=%b done=%b tally=%0d blk=%0d, required ctl=%b tally=15 blk=%0d",
                             p, blk, j, ctl, busy, done, tally, blk_idx, phase_ctl[p], blk);
                else n_pass++;
                if (j == 2) begin
                    case (p)
                        0: msps_f = 1'b1;
                        1: cord_f = 1'b1;
                        default: out_f = 1'b1;
                    endcase
                end
                tick();
                msps_f = 1'b0; cord_f = 1'b0; out_f = 1'b0;
            end
        end
        if (last) begin
            n_chk++;
            if ({ctl, busy, done, tally, blk_idx} !== {C_IDLE, 2'b01, 6'd0, 8'd0})
                $display("FAIL done_pulse_b%0d: ctl=%b busy=%b done=%b tally=%0d blk=%0d, required ctl=%b busy=0 done=1 tally=0 blk=0",
                         blk, ctl, busy, done, tally, blk_idx, C_IDLE);
            else n_pass++;
            tick();
            n_chk++;
            if ({ctl, done} !== {C_IDLE, 1'b0})
                $display("FAIL done_single_b%0d: ctl=%b done=%b, required ctl=%b done=0", blk, ctl, done, C_IDLE);
            else n_pass++;
        end else begin
            n_chk++;
            if ({ctl, done, tally, blk_idx} !== {C_LO, 1'b0, 6'd0, 8'(blk + 1)})
                $display("FAIL no_bubble_b%0d: ctl=%b done=%b tally=%0d blk=%0d, required ctl=%b done=0 tally=0 blk=%0d",
                         blk, ctl, done, tally, blk_idx, C_LO, blk + 1);
            else n_pass++;
        end
    endtask

    task automatic test_single_block();
        blocks = 8'd1;
        enable = 1'b1;
        tick();
        run_block(0, 1'b1, 1'b0);
    endtask

    task automatic test_multi_block();
        blocks = 8'd3;
        enable = 1'b1;
        tick();
        blocks = 8'd1;
        run_block(0, 1'b0, 1'b1);
        run_block(1, 1'b0, 1'b1);
        run_block(2, 1'b1, 1'b0);
    endtask

    task automatic test_continuous();
        blocks = 8'd0;
        enable = 1'b1;
        tick();
        run_block(0, 1'b0, 1'b1);
        run_block(1, 1'b0, 1'b1);
        run_block(2, 1'b0, 1'b1);
        run_block(3, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        blocks = 8'd1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        msps_f = 1'b1;
        tick();
        msps_f = 1'b0;
        n_chk++;
        if (ctl !== C_CORD) $display("FAIL abort_pre_cord: ctl=%b, required %b", ctl, C_CORD);
        else n_pass++;
        cord_f = 1'b1;
        abort = 1'b1;
        tick();
        cord_f = 1'b0;
        abort = 1'b0;
        n_chk++;
        if ({ctl, busy, done, tally, blk_idx} !== {C_IDLE, 2'b00, 6'd0, 8'd0})
            $display("FAIL abort_in_cord: ctl=%b busy=%b done=%b tally=%0d blk=%0d, required ctl=%b busy=0 done=0 tally=0 blk=0",
                     ctl, busy, done, tally, blk_idx, C_IDLE);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if ({ctl, busy, done} !== {C_IDLE, 2'b00})
            $display("FAIL abort_in_idle: ctl=%b busy=%b done=%b, required ctl=%b busy=0 done=0", ctl, busy, done, C_IDLE);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        blocks = 8'd1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_chk++;
        if ({ctl, tally} !== {C_HI, 6'd12})
            $display("FAIL pre_reset_hi: ctl=%b tally=%0d, required ctl=%b tally=12", ctl, tally, C_HI);
        else n_pass++;
        reset = 1'b1;
        msps_f = 1'b1;
        tick();
        reset = 1'b0;
        msps_f = 1'b0;
        n_chk++;
        if ({ctl, busy, done, err, tally, blk_idx} !== {C_IDLE, 3'b000, 6'd0, 8'd0})
            $display("FAIL reset_mid_run: ctl=%b busy=%b done=%b err=%b tally=%0d blk=%0d, required ctl=%b others 0",
                     ctl, busy, done, err, tally, blk_idx, C_IDLE);
        else n_pass++;
    endtask

`ifdef DCT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        blocks = 8'd1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        for (int c = 1; c <= 10; c++) begin
            n_chk++;
            if ({ctl, err} !== {C_MSPS, 1'b0})
                $display("FAIL wdog_wait_c%0d: ctl=%b err=%b, required ctl=%b err=0", c, ctl, err, C_MSPS);
            else n_pass++;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if ({ctl, busy, err} !== {C_ERR, 2'b11})
                $display("FAIL wdog_err_c%0d: ctl=%b busy=%b err=%b, required ctl=%b busy=1 err=1", c, ctl, busy, err, C_ERR);
            else n_pass++;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if ({ctl, busy, err} !== {C_IDLE, 2'b00})
            $display("FAIL wdog_abort: ctl=%b busy=%b err=%b, required ctl=%b busy=0 err=0", ctl, busy, err, C_IDLE);
        else n_pass++;

        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        for (int c = 1; c < 10; c++) tick();
        msps_f = 1'b1;
        tick();
        msps_f = 1'b0;
        n_chk++;
        if ({ctl, err} !== {C_CORD, 1'b0})
            $display("FAIL wdog_flag_wins: ctl=%b err=%b, required ctl=%b err=0", ctl, err, C_CORD);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_continuous();
        test_abort();
        test_reset_mid_run();
`ifdef DCT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: bench did not finish, required completion within 1000000 time units");
        $fatal(1, "time limit");
    end

endmodule
